// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: feeds streamed kernel/image columns to parallel conv lanes and
// buffers tagged lane results in a credit-protected output FIFO
module conv_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int STRIDE      = 1,
  parameter int PE_LATENCY  = 3,
  parameter int OUT_DEPTH   = 4,
  parameter int ACC_WIDTH   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic kernel_reuse,
  input  logic k_valid,
  output logic k_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] k_data,
  input  logic px_valid,
  output logic px_ready,
  input  logic [IMAGE_SIZE*DATA_WIDTH-1:0] px_data,
  output logic lane_kernel_load,
  output logic lane_valid_in,
  output logic [((IMAGE_SIZE-KERNEL_SIZE)/STRIDE+1)*KERNEL_SIZE*DATA_WIDTH-1:0] lane_data,
  input  logic [((IMAGE_SIZE-KERNEL_SIZE)/STRIDE+1)*ACC_WIDTH-1:0] lane_result,
  output logic out_valid,
  input  logic out_ready,
  output logic [((IMAGE_SIZE-KERNEL_SIZE)/STRIDE+1)*ACC_WIDTH-1:0] out_data,
  output logic busy,
  output logic done
);
  localparam int NUM_LANES = (IMAGE_SIZE-KERNEL_SIZE)/STRIDE+1;
  localparam int KCW = $clog2(KERNEL_SIZE)+1;
  localparam int CCW = $clog2(IMAGE_SIZE)+1;
  localparam int OCW = $clog2(NUM_LANES)+1;
  localparam int FCW = $clog2(OUT_DEPTH)+1;
  localparam int PW  = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_KERNEL, STREAM, DRAIN, COMPLETE} state_t;
  state_t state, state_n;
  logic [KCW-1:0] kcol;
  logic [CCW-1:0] col;
  logic [OCW-1:0] popped;
  logic [FCW-1:0] credits, fill;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PE_LATENCY-1:0] tag_pipe;
  logic [NUM_LANES*ACC_WIDTH-1:0] mem [OUT_DEPTH];
  logic kernel_held, k_fire, px_fire, tag, push, pop;
  assign k_fire = k_valid & k_ready;
  assign px_fire = px_valid & px_ready;
  assign lane_kernel_load = k_fire;
  assign lane_valid_in = k_fire | px_fire;
  // only columns whose window start lands on the stride grid produce an output column
  assign tag = px_fire && col >= CCW'(KERNEL_SIZE-1) &&
               ((col - CCW'(KERNEL_SIZE-1)) % CCW'(STRIDE)) == '0;
  assign push = tag_pipe[PE_LATENCY-1];
  assign out_valid = fill != '0;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_data[i*KERNEL_SIZE*DATA_WIDTH +: KERNEL_SIZE*DATA_WIDTH] = k_fire ? k_data :
        px_fire ? px_data[i*STRIDE*DATA_WIDTH +: KERNEL_SIZE*DATA_WIDTH] : '0;
  end
  always_comb begin
    state_n = state;
    k_ready = state == LOAD_KERNEL;
    px_ready = state == STREAM && credits != '0;
    busy = state != IDLE;
    done = state == COMPLETE;
    case (state)
      IDLE: if (start) state_n = (kernel_reuse && kernel_held) ? STREAM : LOAD_KERNEL;
      LOAD_KERNEL: if (k_valid && kcol == KCW'(KERNEL_SIZE-1)) state_n = STREAM;
      STREAM: if (px_valid && credits != '0 && col == CCW'(IMAGE_SIZE-1)) state_n = DRAIN;
      DRAIN: if (tag_pipe == '0 && fill == '0 && popped == OCW'(NUM_LANES)) state_n = COMPLETE;
      COMPLETE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      kcol <= '0;
      col <= '0;
      popped <= '0;
      credits <= FCW'(OUT_DEPTH);
      fill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag_pipe <= '0;
      kernel_held <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        kcol <= '0;
        col <= '0;
        popped <= '0;
      end
      if (k_fire) kcol <= kcol + 1'b1;
      if (k_fire && kcol == KCW'(KERNEL_SIZE-1)) kernel_held <= 1'b1;
      if (px_fire) col <= col + 1'b1;
      tag_pipe <= (tag_pipe << 1) | PE_LATENCY'(tag);
      credits <= credits - FCW'(tag) + FCW'(pop);
      fill <= fill + FCW'(push) - FCW'(pop);
      if (push) wr_ptr <= wr_ptr == PW'(OUT_DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == PW'(OUT_DEPTH-1) ? '0 : rd_ptr + 1'b1;
        popped <= popped + 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= lane_result;
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: directed frame scenarios for conv_stream_ctrl; lanes are modelled
// as a PE_LATENCY delay line returning the per-lane sum of the words they were fed
`timescale 1ns/1ps
module tb_conv_stream_ctrl;
  localparam int DW = 16, K = 5, N = 28, P = 3, D = 4, AW = 32;
  localparam int L1 = N - K + 1, L2 = (N - K) / 2 + 1;
  localparam int LD1 = L1*K*DW, LR1 = L1*AW, LD2 = L2*K*DW, LR2 = L2*AW;

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic start = 0, kernel_reuse = 0, k_valid = 0, px_valid = 0, out_ready = 0;
  logic [K*DW-1:0] k_data = '0;
  logic [N*DW-1:0] px_data = '0;
  logic k_ready, px_ready, lane_kernel_load, lane_valid_in, out_valid, busy, done;
  logic [LD1-1:0] lane_data;
  logic [LR1-1:0] lane_result, out_data;

  logic s2_start = 0, s2_reuse = 0, s2_k_valid = 0, s2_px_valid = 0, s2_out_ready = 0;
  logic [K*DW-1:0] s2_k_data = '0;
  logic [N*DW-1:0] s2_px_data = '0;
  logic s2_k_ready, s2_px_ready, s2_lane_kernel_load, s2_lane_valid_in, s2_out_valid, s2_busy, s2_done;
  logic [LD2-1:0] s2_lane_data;
  logic [LR2-1:0] s2_lane_result, s2_out_data;

  int tests = 0, fails = 0;

  typedef struct {
    int nout, ndone, kb, pc, bad, lerr, c4, fov, stall_pc;
    logic ksaw, first_pxr, stall_pxr;
  } stats_t;

  conv_stream_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_SIZE(N), .STRIDE(1),
                     .PE_LATENCY(P), .OUT_DEPTH(D), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_reuse(kernel_reuse),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .lane_kernel_load(lane_kernel_load), .lane_valid_in(lane_valid_in), .lane_data(lane_data),
    .lane_result(lane_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  conv_stream_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_SIZE(N), .STRIDE(2),
                     .PE_LATENCY(P), .OUT_DEPTH(D), .ACC_WIDTH(AW)) dut_s2 (
    .clk(clk), .rst(rst), .start(s2_start), .kernel_reuse(s2_reuse),
    .k_valid(s2_k_valid), .k_ready(s2_k_ready), .k_data(s2_k_data),
    .px_valid(s2_px_valid), .px_ready(s2_px_ready), .px_data(s2_px_data),
    .lane_kernel_load(s2_lane_kernel_load), .lane_valid_in(s2_lane_valid_in), .lane_data(s2_lane_data),
    .lane_result(s2_lane_result), .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_data(s2_out_data),
    .busy(s2_busy), .done(s2_done));

  function automatic logic [LR1-1:0] sums(input logic [LD1-1:0] d, input int nl);
    logic [LR1-1:0] s;
    int acc;
    s = '0;
    for (int i = 0; i < nl; i++) begin
      acc = 0;
      for (int r = 0; r < K; r++) acc += int'($signed(d[(i*K+r)*DW +: DW]));
      s[i*AW +: AW] = acc;
    end
    return s;
  endfunction

  // closed form of the lane sum over rows i*s .. i*s+K-1 of pixel seed+32*c+r
  function automatic logic [LR1-1:0] exp_col(input int seed, input int c, input int s, input int nl);
    logic [LR1-1:0] v;
    v = '0;
    for (int i = 0; i < nl; i++) v[i*AW +: AW] = K*(seed + 32*c) + K*i*s + K*(K-1)/2;
    return v;
  endfunction

  function automatic logic [N*DW-1:0] img(input int seed, input int c);
    logic [N*DW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(seed + 32*c + r);
    return v;
  endfunction

  function automatic logic [K*DW-1:0] kcol(input int seed, input int kb);
    logic [K*DW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = DW'(seed*3 + kb*K + r);
    return v;
  endfunction

  logic [LR1-1:0] pe1 [P];
  logic [LR2-1:0] pe2 [P];
  always @(posedge clk) begin
    pe1[0] <= lane_valid_in && !lane_kernel_load ? sums(lane_data, L1) : '0;
    pe2[0] <= s2_lane_valid_in && !s2_lane_kernel_load ? LR2'(sums(LD1'(s2_lane_data), L2)) : '0;
    for (int j = 1; j < P; j++) begin
      pe1[j] <= pe1[j-1];
      pe2[j] <= pe2[j-1];
    end
  end
  assign lane_result = pe1[P-1];
  assign s2_lane_result = pe2[P-1];

  // omode: 0 = out_ready high, 1 = random, 2 = held low until cycle 60
  task automatic run_frame(input int seed, input logic reuse, input logic gaps, input int omode,
                           input int abort_col, output stats_t st);
    int dcyc;
    logic [LR1-1:0] expv;
    dcyc = -1;
    st = '{default: 0};
    st.c4 = -1;
    st.fov = -1;
    st.stall_pc = -1;
    for (int cyc = 0; cyc < 3000 && !(dcyc >= 0 && cyc > dcyc + 4); cyc++) begin
      @(negedge clk);
      start = cyc == 0;
      kernel_reuse = reuse;
      k_valid = st.kb < K && (!gaps || $urandom_range(1) == 1);
      k_data = kcol(seed, st.kb);
      px_valid = st.pc < N && (!gaps || $urandom_range(1) == 1);
      px_data = img(seed, st.pc);
      out_ready = omode == 0 ? 1'b1 : omode == 1 ? $urandom_range(1) == 1 : cyc >= 60;
      if (st.pc == abort_col) begin
        rst = 0;
        return;
      end
      #1;
      if (k_ready) st.ksaw = 1;
      if (cyc == 1) st.first_pxr = px_ready;
      if (cyc == 40) begin
        st.stall_pc = st.pc;
        st.stall_pxr = px_ready;
      end
      if (k_valid && k_ready) begin
        if (!lane_kernel_load || !lane_valid_in || lane_data !== {L1{k_data}}) st.lerr++;
        st.kb++;
      end else if (px_valid && px_ready) begin
        if (lane_kernel_load || !lane_valid_in) st.lerr++;
        if (st.pc == K - 1) st.c4 = cyc;
        st.pc++;
      end else if (lane_valid_in || lane_kernel_load) st.lerr++;
      if (out_valid && st.fov < 0) st.fov = cyc;
      if (out_valid && out_ready) begin
        expv = exp_col(seed, K - 1 + st.nout, 1, L1);
        if (out_data !== expv) begin
          st.bad++;
          $display("[TB] seed %0d out %0d lane0 got %h want %h", seed, st.nout, out_data[AW-1:0], expv[AW-1:0]);
        end
        st.nout++;
      end
      if (done) begin
        st.ndone++;
        dcyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({k_ready, px_ready, lane_kernel_load, lane_valid_in, out_valid, busy, done} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000000", {k_ready, px_ready, lane_kernel_load, lane_valid_in, out_valid, busy, done});
    end
    tests++;
    if (lane_data !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_data got lane %h out %h want 0", lane_data[31:0], out_data[31:0]);
    end
    tests++;
    if ({s2_k_ready, s2_px_ready, s2_out_valid, s2_busy, s2_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_s2 got %b want 00000", {s2_k_ready, s2_px_ready, s2_out_valid, s2_busy, s2_done});
    end
    rst = 1;
  endtask

  task automatic test_basic();
    stats_t st;
    run_frame(100, 0, 0, 0, -1, st);
    tests++;
    if (st.kb != 5) begin fails++; $display("FAIL basic_kbeats got %0d want 5", st.kb); end
    tests++;
    if (st.lerr != 0) begin fails++; $display("FAIL basic_lane_ctrl got %0d bad beats want 0", st.lerr); end
    tests++;
    if (st.nout != 24 || st.bad != 0) begin fails++; $display("FAIL basic_outputs got %0d cols %0d bad want 24 cols 0 bad", st.nout, st.bad); end
    tests++;
    if (st.ndone != 1) begin fails++; $display("FAIL basic_done got %0d pulses want 1", st.ndone); end
    // accepted at the edge ending cycle c4, pushed PE_LATENCY edges later, visible the cycle after
    tests++;
    if (st.fov - st.c4 != 4) begin fails++; $display("FAIL basic_latency got %0d cycles want 4", st.fov - st.c4); end
  endtask

  task automatic test_reuse();
    stats_t st;
    run_frame(100, 1, 0, 0, -1, st);
    tests++;
    if (st.ksaw !== 1'b0 || st.kb != 0) begin fails++; $display("FAIL reuse_no_kload got k_ready %b beats %0d want 0 0", st.ksaw, st.kb); end
    tests++;
    if (st.first_pxr !== 1'b1) begin fails++; $display("FAIL reuse_stream_entry got px_ready %b want 1", st.first_pxr); end
    tests++;
    if (st.nout != 24 || st.bad != 0 || st.ndone != 1) begin
      fails++;
      $display("FAIL reuse_outputs got %0d cols %0d bad %0d done want 24 0 1", st.nout, st.bad, st.ndone);
    end
  endtask

  task automatic test_backpressure();
    stats_t st;
    run_frame(-3000, 1, 0, 2, -1, st);
    tests++;
    if (st.stall_pc != 8 || st.stall_pxr !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall got %0d cols px_ready %b want 8 cols px_ready 0", st.stall_pc, st.stall_pxr);
    end
    tests++;
    if (st.nout != 24 || st.bad != 0 || st.ndone != 1) begin
      fails++;
      $display("FAIL bp_outputs got %0d cols %0d bad %0d done want 24 0 1", st.nout, st.bad, st.ndone);
    end
  endtask

  task automatic test_stride();
    int kb, pc, nout, ndone, bad, dcyc;
    kb = 0; pc = 0; nout = 0; ndone = 0; bad = 0; dcyc = -1;
    for (int cyc = 0; cyc < 2000 && !(dcyc >= 0 && cyc > dcyc + 4); cyc++) begin
      @(negedge clk);
      s2_start = cyc == 0;
      s2_k_valid = kb < K;
      s2_k_data = kcol(7, kb);
      s2_px_valid = pc < N;
      s2_px_data = img(700, pc);
      s2_out_ready = 1;
      #1;
      if (s2_k_valid && s2_k_ready) kb++;
      if (s2_px_valid && s2_px_ready) pc++;
      if (s2_out_valid && s2_out_ready) begin
        if (s2_out_data !== LR2'(exp_col(700, K - 1 + 2*nout, 2, L2))) bad++;
        nout++;
      end
      if (s2_done) begin
        ndone++;
        dcyc = cyc;
      end
    end
    tests++;
    if (kb != 5 || pc != 28) begin fails++; $display("FAIL stride_beats got k %0d px %0d want 5 28", kb, pc); end
    tests++;
    if (nout != 12 || bad != 0) begin fails++; $display("FAIL stride_outputs got %0d cols %0d bad want 12 0", nout, bad); end
    tests++;
    if (ndone != 1) begin fails++; $display("FAIL stride_done got %0d want 1", ndone); end
  endtask

  task automatic test_abort();
    stats_t st;
    int nd;
    nd = 0;
    run_frame(200, 1, 0, 0, 10, st);
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if (st.pc != 10) begin fails++; $display("FAIL abort_reached got col %0d want 10", st.pc); end
    tests++;
    if ({k_ready, px_ready, lane_kernel_load, lane_valid_in, out_valid, busy, done} !== 7'b0) begin
      fails++;
      $display("FAIL abort_ctrl got %b want 0000000", {k_ready, px_ready, lane_kernel_load, lane_valid_in, out_valid, busy, done});
    end
    tests++;
    if (lane_data !== '0 || out_data !== '0) begin fails++; $display("FAIL abort_data got lane %h out %h want 0", lane_data[31:0], out_data[31:0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (done) nd++;
    end
    tests++;
    if (nd != 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", nd); end
    run_frame(300, 1, 0, 0, -1, st);
    tests++;
    if (st.kb != 5 || st.ksaw !== 1'b1) begin fails++; $display("FAIL abort_reload got %0d beats want 5", st.kb); end
    tests++;
    if (st.nout != 24 || st.bad != 0 || st.ndone != 1) begin
      fails++;
      $display("FAIL abort_next_frame got %0d cols %0d bad %0d done want 24 0 1", st.nout, st.bad, st.ndone);
    end
  endtask

  task automatic test_random();
    stats_t st;
    for (int f = 0; f < 3; f++) begin
      run_frame(1000 + 3000*f, f == 1, 1, 1, -1, st);
      tests++;
      if (st.nout != 24 || st.bad != 0 || st.lerr != 0) begin
        fails++;
        $display("FAIL random_f%0d got %0d cols %0d bad %0d lane errs want 24 0 0", f, st.nout, st.bad, st.lerr);
      end
      tests++;
      if (st.ndone != 1) begin fails++; $display("FAIL random_done_f%0d got %0d want 1", f, st.ndone); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_reuse();
    test_backpressure();
    test_stride();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
